// File: rtl/uart_sample_unpacker.sv
// uart_sample_unpacker: parses framed H/Y complex-sample blocks from a UART byte stream
module uart_sample_unpacker #(
  parameter int N = 32,
  parameter int H_COUNT = 16,
  parameter int Y_COUNT = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [N-1:0] H_re_out,
  output logic [N-1:0] H_im_out,
  output logic         H_value_ready,
  output logic [N-1:0] Y_re_out,
  output logic [N-1:0] Y_im_out,
  output logic         Y_value_ready,
  output logic         frame_done,
  output logic         frame_err,
  output logic [1:0]   err_code
);
  localparam int B = N / 8;
  localparam int BW = $clog2(2 * B);
  localparam int CW = $clog2((H_COUNT > Y_COUNT ? H_COUNT : Y_COUNT) + 1);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, CHK} state_t;
  state_t state;
  logic is_y;
  logic [7:0] chk;
  logic [BW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [N-1:0] re_acc, im_acc, re_next, im_next;
  logic [GW-1:0] gap;
  logic timeout, last_byte, last_sample;
  // next-state helpers: shifted accumulators and end-of-sample/frame/timeout detection
  always_comb begin
    re_next = N'({re_acc, rx_data});
    im_next = N'({im_acc, rx_data});
    last_byte = idx == BW'(2 * B - 1);
    last_sample = cnt == (is_y ? CW'(Y_COUNT - 1) : CW'(H_COUNT - 1));
    timeout = state != IDLE && !rx_valid && gap == GW'(TIMEOUT_CYCLES - 1);
  end
  // frame FSM with registered sample outputs and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      is_y <= 1'b0;
      chk <= '0;
      idx <= '0;
      cnt <= '0;
      re_acc <= '0;
      im_acc <= '0;
      gap <= '0;
      H_re_out <= '0;
      H_im_out <= '0;
      H_value_ready <= 1'b0;
      Y_re_out <= '0;
      Y_im_out <= '0;
      Y_value_ready <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'b00;
    end else begin
      H_value_ready <= 1'b0;
      Y_value_ready <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      gap <= (state == IDLE || rx_valid || timeout) ? '0 : gap + 1'b1;
      if (timeout) begin
        frame_err <= 1'b1;
        err_code <= 2'b11;
        state <= IDLE;
        idx <= '0;
        cnt <= '0;
        re_acc <= '0;
        im_acc <= '0;
      end else if (rx_valid) begin
        case (state)
          IDLE: if (rx_data == 8'hA5) state <= TYPE;
          TYPE: begin
            if (rx_data == 8'h48 || rx_data == 8'h59) begin
              is_y <= rx_data == 8'h59;
              chk <= rx_data;
              idx <= '0;
              cnt <= '0;
              state <= PAYLOAD;
            end else begin
              frame_err <= 1'b1;
              err_code <= 2'b01;
              state <= IDLE;
            end
          end
          PAYLOAD: begin
            chk <= chk ^ rx_data;
            if (idx < BW'(B)) re_acc <= re_next;
            else im_acc <= im_next;
            idx <= last_byte ? '0 : idx + 1'b1;
            if (last_byte) begin
              cnt <= cnt + 1'b1;
              if (last_sample) state <= CHK;
              if (is_y) begin
                Y_re_out <= re_acc;
                Y_im_out <= im_next;
                Y_value_ready <= 1'b1;
              end else begin
                H_re_out <= re_acc;
                H_im_out <= im_next;
                H_value_ready <= 1'b1;
              end
            end
          end
          default: begin
            frame_done <= rx_data == chk;
            frame_err <= rx_data != chk;
            err_code <= rx_data == chk ? 2'b00 : 2'b10;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_sample_unpacker.sv
// tb_uart_sample_unpacker: scoreboard bench for the H/Y sample frame parser
module tb_uart_sample_unpacker;
  localparam int N = 32;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0;
  logic [N-1:0] H_re_out, H_im_out, Y_re_out, Y_im_out;
  logic H_value_ready, Y_value_ready, frame_done, frame_err;
  logic [1:0] err_code;
  typedef struct {
    logic [1:0] kind;
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic [1:0] code;
    int at;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0;
  uart_sample_unpacker #(.N(N), .H_COUNT(16), .Y_COUNT(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .H_re_out(H_re_out), .H_im_out(H_im_out), .H_value_ready(H_value_ready),
    .Y_re_out(Y_re_out), .Y_im_out(Y_im_out), .Y_value_ready(Y_value_ready),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
  );
  always #10 clk = ~clk;
  // edge counter: after edge k the outputs it produced are read with cyc == k
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  task automatic push(input logic [1:0] kind, input logic [N-1:0] re, input logic [N-1:0] im, input logic [1:0] code, input int at);
    q.push_back('{kind, re, im, code, at});
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    repeat (gap) @(negedge clk);
  endtask
  // kind: 0 H sample, 1 Y sample, 2 frame_done, 3 frame_err
  task automatic send_frame(input logic [7:0] typ, input int cnt, input logic [N-1:0] re0, input logic [N-1:0] im0, input logic [7:0] flip, input int gap);
    logic [7:0] c;
    logic [N-1:0] re, im;
    send(8'hA5, gap);
    send(typ, gap);
    c = typ;
    for (int i = 0; i < cnt; i++) begin
      re = re0 + N'(i);
      im = im0 + N'(i);
      for (int k = N / 8 - 1; k >= 0; k--) begin
        c ^= re[8*k+:8];
        send(re[8*k+:8], gap);
      end
      for (int k = N / 8 - 1; k >= 0; k--) begin
        c ^= im[8*k+:8];
        if (k == 0) push(typ == 8'h59 ? 2'd1 : 2'd0, re, im, 2'd0, cyc + 1);
        send(im[8*k+:8], gap);
      end
    end
    push(flip == 0 ? 2'd2 : 2'd3, '0, '0, flip == 0 ? 2'd0 : 2'd2, cyc + 1);
    send(c ^ flip, gap);
  endtask
  // monitor: every status/data pulse must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] k;
    if (H_value_ready | Y_value_ready | frame_done | frame_err) begin
      k = H_value_ready ? 2'd0 : Y_value_ready ? 2'd1 : frame_done ? 2'd2 : 2'd3;
      check("pulse_onehot", $countones({H_value_ready, Y_value_ready, frame_done, frame_err}), 1);
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cycle", cyc, e.at);
        if (k == 0) begin
          check("H_re", H_re_out, e.re);
          check("H_im", H_im_out, e.im);
        end else if (k == 1) begin
          check("Y_re", Y_re_out, e.re);
          check("Y_im", Y_im_out, e.im);
        end else check("err_code", err_code, e.code);
      end
    end
  end
  initial begin
    int le;
    logic [7:0] yb [0:12];
    yb = '{8'hA5, 8'h59, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'h11, 8'h22, 8'h33};
    repeat (3) @(negedge clk);
    check("rst_H_re", H_re_out, 0);
    check("rst_Y_im", Y_im_out, 0);
    check("rst_err_code", err_code, 0);
    check("rst_pulses", {H_value_ready, Y_value_ready, frame_done, frame_err}, 0);
    rst = 0;
    @(negedge clk);
    send(8'h37, 0);
    send(8'h48, 1);
    send_frame(8'h48, 16, 32'h00400000, 32'hFFC00000, 8'h00, 1);
    repeat (3) @(negedge clk);
    send_frame(8'h59, 8, 32'h80000001, 32'h7FFFFFFE, 8'h00, 0);
    repeat (3) @(negedge clk);
    send(8'hA5, 0);
    push(2'd3, '0, '0, 2'd1, cyc + 1);
    send(8'h11, 0);
    repeat (5) @(negedge clk);
    check("err_code_hold", err_code, 2'd1);
    send_frame(8'h59, 8, 32'h0000A5A5, 32'hA5000000, 8'h00, 2);
    send_frame(8'h48, 16, 32'h00400000, 32'hFFC00000, 8'h01, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      if (i == 9) push(2'd1, 32'h01020304, 32'hF5F6F7F8, 2'd0, cyc + 1);
      le = cyc + 1;
      send(yb[i], 0);
    end
    push(2'd3, '0, '0, 2'd3, le + 100);
    repeat (110) @(negedge clk);
    check("timeout_err_code", err_code, 2'd3);
    send_frame(8'h59, 8, 32'h00000010, 32'hFFFFFFF0, 8'h00, 0);
    send(8'hA5, 0);
    send(8'h48, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    rx_data = 8'h33;
    rx_valid = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
    rx_valid = 0;
    check("midrst_H_re", H_re_out, 0);
    check("midrst_H_im", H_im_out, 0);
    check("midrst_Y_re", Y_re_out, 0);
    check("midrst_Y_im", Y_im_out, 0);
    check("midrst_err_code", err_code, 0);
    check("midrst_pulses", {H_value_ready, Y_value_ready, frame_done, frame_err}, 0);
    send_frame(8'h48, 16, 32'h12345678, 32'hFEDCBA98, 8'h00, 0);
    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
